// File: rtl/led_flow_monitor.sv
// rtl/led_flow_monitor.sv - flowing-light LED bus monitor: locks onto the lit LED, tracks steps/direction, flags stalls and illegal moves
module led_flow_monitor #(
    parameter int STALL_MAX = 1000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] led_in,
    input  logic        clear_err,
    output logic [3:0]  pos,
    output logic        valid,
    output logic        dir,
    output logic        rev,
    output logic [15:0] step_cnt,
    output logic        stall,
    output logic        err
);

    localparam int CW = (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STALL_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOCK,
        S_TRACK,
        S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   led_cur_q, led_cur_d;
    logic [15:0]   led_prev_q, led_prev_d;
    logic [3:0]    pos_q, pos_d;
    logic          dir_q, dir_d;
    logic          rev_q, rev_d;
    logic [15:0]   step_q, step_d;
    logic          stall_q, stall_d;
    logic [CW-1:0] scnt_q, scnt_d;

    logic [3:0]    idx;
    logic          legal;
    logic          evt;
    logic [3:0]    pos_up;
    logic [3:0]    pos_dn;
    logic          is_up;
    logic          is_dn;

    // Priority encoder is only meaningful when legal (exactly one bit set).
    always_comb begin
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (led_cur_q[i]) begin
                idx = 4'(i);
            end
        end
    end

    assign legal  = (led_cur_q != 16'd0) && ((led_cur_q & (led_cur_q - 16'd1)) == 16'd0);
    assign evt    = (led_cur_q != led_prev_q);
    assign pos_up = pos_q + 4'd1;
    assign pos_dn = pos_q - 4'd1;
    assign is_up  = legal && (idx == pos_up);
    assign is_dn  = legal && (idx == pos_dn);

    always_comb begin
        led_cur_d  = led_in;
        led_prev_d = led_cur_q;
        state_d    = state_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        rev_d      = 1'b0;
        step_d     = step_q;
        stall_d    = stall_q;
        scnt_d     = '0;

        case (state_q)
            S_IDLE: begin
                if (evt && legal) begin
                    state_d = S_LOCK;
                    pos_d   = idx;
                end
            end
            S_LOCK: begin
                if (evt) begin
                    if (is_up || is_dn) begin
                        state_d = S_TRACK;
                        pos_d   = idx;
                        dir_d   = is_dn;
                        step_d  = 16'd1;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_TRACK: begin
                if (evt) begin
                    if (is_up || is_dn) begin
                        pos_d   = idx;
                        dir_d   = is_dn;
                        rev_d   = (is_dn != dir_q);
                        stall_d = 1'b0;
                        if (step_q != 16'hFFFF) begin
                            step_d = step_q + 16'd1;
                        end
                    end else begin
                        state_d = S_ERROR;
                    end
                end else begin
                    // Counter parks at the threshold so stall stays up until the next step.
                    scnt_d = (scnt_q == SMAX) ? scnt_q : scnt_q + CW'(1);
                    if (scnt_d == SMAX) begin
                        stall_d = 1'b1;
                    end
                end
            end
            S_ERROR: begin
                if (clear_err) begin
                    state_d = S_IDLE;
                    step_d  = 16'd0;
                    stall_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            led_cur_q  <= 16'd0;
            led_prev_q <= 16'd0;
            pos_q      <= 4'd0;
            dir_q      <= 1'b0;
            rev_q      <= 1'b0;
            step_q     <= 16'd0;
            stall_q    <= 1'b0;
            scnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            led_cur_q  <= led_cur_d;
            led_prev_q <= led_prev_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            rev_q      <= rev_d;
            step_q     <= step_d;
            stall_q    <= stall_d;
            scnt_q     <= scnt_d;
        end
    end

    assign pos      = pos_q;
    assign valid    = (state_q == S_LOCK) || (state_q == S_TRACK);
    assign dir      = dir_q;
    assign rev      = rev_q;
    assign step_cnt = step_q;
    assign stall    = stall_q;
    assign err      = (state_q == S_ERROR);

endmodule
